// File: rtl/seq_detect_mealy.sv
// Serial detector for the bit pattern 1101 with overlapping matches.
// Mealy output: y pulses while the completing '1' is on din.
module seq_detect_mealy (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic y
);

  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S11  = 2'b10,
    S110 = 2'b11
  } state_e;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    y       = 1'b0;
    unique case (state_q)
      S0: begin
        state_d = din ? S1 : S0;
      end
      S1: begin
        state_d = din ? S11 : S0;
      end
      S11: begin
        state_d = din ? S11 : S110;
      end
      S110: begin
        // the completing '1' seeds the next match
        state_d = din ? S1 : S0;
        y       = din & ~rst;
      end
      default: begin
        state_d = S0;
        y       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Self-checking bench for seq_detect_mealy.
// Reference model: sliding window of the bits seen since the last reset.
module tb_seq_detect_mealy;

  logic clk;
  logic rst;
  logic din;
  logic y;

  int errors;
  int checks;

  logic [2:0] m_hist;
  int         m_cnt;

  seq_detect_mealy dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_hit(input logic b);
    return (m_cnt >= 3) && ({m_hist, b} == 4'b1101);
  endfunction

  function automatic void m_push(input logic b);
    m_hist = {m_hist[1:0], b};
    m_cnt  = m_cnt + 1;
  endfunction

  function automatic void m_clear();
    m_hist = 3'b000;
    m_cnt  = 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (y !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: y=%b expected 0", i, y);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    m_clear();
    // 1 -> S1, 1 -> S11, 0 -> S110, 1 -> match
    for (int i = 0; i < 4; i++) begin
      logic [3:0] pat;
      logic [3:0] exp;
      pat = 4'b1101;
      exp = 4'b0001;
      din = pat[3-i];
      @(negedge clk);
      checks++;
      if (y !== exp[3-i]) begin
        errors++;
        $display("FAIL reset_release[%0d]: y=%b expected %b", i, y, exp[3-i]);
      end
      @(posedge clk);
      #1;
      m_push(pat[3-i]);
    end
  endtask

  task automatic test_overlap();
    logic [10:0] pat;
    logic [10:0] exp;
    pat = 11'b11011011101;
    exp = 11'b00010010001;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      din = pat[10-i];
      @(negedge clk);
      checks++;
      if (y !== exp[10-i]) begin
        errors++;
        $display("FAIL overlap bit%0d: y=%b expected %b", i + 1, y, exp[10-i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stream();
    logic [15:0] pat;
    logic [15:0] exp;
    pat = 16'b0111011010110101;
    exp = 16'b0000010010000100;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din = 1'b0;
      @(negedge clk);
      checks++;
      if (y !== 1'b0) begin
        errors++;
        $display("FAIL stream_idle[%0d]: y=%b expected 0", i, y);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) begin
      din = pat[15-i];
      @(negedge clk);
      checks++;
      if (y !== exp[15-i]) begin
        errors++;
        $display("FAIL stream bit%0d: y=%b expected %b", i + 1, y, exp[15-i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_near_miss();
    logic [14:0] pat;
    pat = 15'b110010010101111;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 15; i++) begin
        din = pat[14-i];
        @(negedge clk);
        checks++;
        if (y !== 1'b0) begin
          errors++;
          $display("FAIL near_miss r%0d bit%0d: y=%b expected 0", r, i + 1, y);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre;
    logic [3:0] post;
    pre  = 3'b110;
    post = 4'b1101;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din = pre[2-i];
      @(negedge clk);
      checks++;
      if (y !== m_hit(pre[2-i])) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d]: y=%b expected %b", i, y, m_hit(pre[2-i]));
      end
      @(posedge clk);
      #1;
      m_push(pre[2-i]);
    end
    // state is S110 with din=1: reset must still mask y
    rst = 1'b1;
    din = 1'b1;
    @(negedge clk);
    checks++;
    if (y !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mask: y=%b expected 0", y);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_clear();
    for (int i = 0; i < 4; i++) begin
      din = post[3-i];
      @(negedge clk);
      checks++;
      if (y !== m_hit(post[3-i])) begin
        errors++;
        $display("FAIL reset_mid_post[%0d]: y=%b expected %b", i, y, m_hit(post[3-i]));
      end
      @(posedge clk);
      #1;
      m_push(post[3-i]);
    end
  endtask

  task automatic test_mealy_timing();
    logic [2:0] pre;
    pre = 3'b110;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din = pre[2-i];
      @(posedge clk);
      #1;
      m_push(pre[2-i]);
    end
    din = 1'b0;
    #1;
    checks++;
    if (y !== m_hit(1'b0)) begin
      errors++;
      $display("FAIL mealy_din0: y=%b expected %b", y, m_hit(1'b0));
    end
    #2;
    din = 1'b1;
    #1;
    checks++;
    if (y !== m_hit(1'b1)) begin
      errors++;
      $display("FAIL mealy_din1: y=%b expected %b", y, m_hit(1'b1));
    end
    @(posedge clk);
    #1;
    m_push(1'b1);
    checks++;
    if (y !== m_hit(1'b1)) begin
      errors++;
      $display("FAIL mealy_after_edge: y=%b expected %b", y, m_hit(1'b1));
    end
    din = 1'b0;
    #1;
    checks++;
    if (y !== m_hit(1'b0)) begin
      errors++;
      $display("FAIL mealy_after_edge_d0: y=%b expected %b", y, m_hit(1'b0));
    end
    @(posedge clk);
    #1;
    m_push(1'b0);
  endtask

  task automatic test_idle();
    logic [2:0] tail;
    tail = 3'b101;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din = 1'b1;
      @(posedge clk);
      #1;
      m_push(1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      din = 1'b0;
      @(negedge clk);
      checks++;
      if (y !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero[%0d]: y=%b expected 0", i, y);
      end
      @(posedge clk);
      #1;
      m_push(1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      din = tail[2-i];
      @(negedge clk);
      checks++;
      if (y !== m_hit(tail[2-i])) begin
        errors++;
        $display("FAIL idle_tail[%0d]: y=%b expected %b", i, y, m_hit(tail[2-i]));
      end
      @(posedge clk);
      #1;
      m_push(tail[2-i]);
    end
  endtask

  task automatic test_random();
    logic b;
    logic r;
    int   hits;
    hits = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 39) == 0);
      din = b;
      rst = r;
      @(negedge clk);
      checks++;
      if (r) begin
        if (y !== 1'b0) begin
          errors++;
          $display("FAIL random_rst[%0d]: y=%b expected 0", i, y);
        end
      end else begin
        if (y !== m_hit(b)) begin
          errors++;
          $display("FAIL random[%0d]: din=%b y=%b expected %b", i, b, y, m_hit(b));
        end
        if (m_hit(b)) hits++;
      end
      @(posedge clk);
      #1;
      if (r) m_clear();
      else m_push(b);
    end
    rst = 1'b0;
    checks++;
    if (hits == 0) begin
      errors++;
      $display("FAIL random_coverage: hits=%0d expected >0", hits);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    din    = 1'b0;
    m_clear();
    #1;
    test_reset();
    test_overlap();
    test_stream();
    test_near_miss();
    test_reset_mid();
    test_mealy_timing();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_mealy.md
Name: seq_detect_mealy

Overview:
- Serial bit-stream pattern detector for the fixed sequence 1101, MSB-first, with overlapping matches allowed.
- Implemented as a 4-state Mealy FSM.
- Output y is a combinational pulse asserted during the cycle in which the final '1' of a match is present on din.
- Sits after a bit-serialiser or synchroniser; consumers register y on the same clock edge that consumes the completing bit.

Parameters:
- None. The pattern (1101) and its overlap behaviour are fixed in RTL.

Ports:
- clk  input  1  rising-edge clock; din is sampled on each rising edge.
- rst  input  1  synchronous, active-high reset; forces the FSM to IDLE on the next rising edge.
- din  input  1  serial data bit, one bit per clock, held stable around the rising edge.
- y    output 1  match flag (Mealy): 1 when the current state is S110 and din=1; otherwise 0.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- State register: 2 bits, binary encoding.
  - S0 (IDLE, no useful prefix) = 00
  - S1 (seen "1") = 01
  - S11 (seen "11") = 10
  - S110 (seen "110") = 11
- Reset:
  - rst=1 at a rising edge loads S0.
  - While rst=1, y is forced to 0 regardless of state and din.
  - Reset mid-pattern discards the partial match; no detection can span a reset.
- Transitions on each rising edge with rst=0 (din=0 / din=1):
  - S0 -> S0 / S1
  - S1 -> S0 / S11
  - S11 -> S110 / S11 (extra 1s keep the "11" prefix)
  - S110 -> S0 / S1 (match; the trailing '1' is reused as the prefix "1" for overlap)
- Output:
  - y = (state==S110) & din & ~rst, purely combinational.
  - Zero latency: y rises in the same cycle the completing bit is applied; no registered output.
  - y may glitch with din; downstream logic samples it only at the clock edge.
- Overlap: "1101101" yields two matches (bits 4 and 7, 1-based). Suffix "1" of a match seeds the next.
- Back-to-back: minimum spacing between y pulses is 3 bits ("1101101").
- Idle input (din held 0) from any state reaches S0 in at most 2 cycles; y stays 0.
- Illegal or unreachable encodings: none, since all four 2-bit codes are used. A default branch goes to S0.
- No X propagation: every state and output must be fully assigned in every branch.

Test Plan:
- Reset: hold rst=1 for 2 edges with din=1 -> state S0, y=0 throughout; release -> first 1 goes to S1.
- Overlap stream 11011011101 (first bit first, one bit per clock) -> y=1 exactly during bits 4, 7 and 11 (1-based); 0 elsewhere.
- Stream 0111011010110101 after 3 idle zeros -> y=1 exactly during bits 6, 9 and 14 (1-based); the run "111" before the 0 must not suppress the match.
- Near-miss patterns 1100, 1001, 0101, 111 repeated -> y never asserts.
- Reset mid-match: apply 110, assert rst for 1 edge, then apply 1 -> y=0 (no match); then apply 101 -> y=1 on the final 1.
- Mealy timing: in state S110, toggle din 0->1 mid-cycle before the edge -> y follows din combinationally. After the edge with din=1, the state is S1 and y=0 unless a new match completes.
